mips_cpu_sequencer: RTL
=======================

Name: mips_cpu_sequencer

Overview:
Owns the multicycle state register that the combinational control decoder consumes, so the decoder only maps (opcode, state) to datapath controls. Supports variable instruction length (1..MAX_EXEC exec cycles), memory waitrequest stalls, a fixed-latency mult/div wait phase, halt on jump-to-zero, and a retired-instruction counter. Sits between the top-level CPU wrapper (bus handshake, halt request) and the control decoder (state input).

Parameters:
MAX_EXEC, 3, maximum exec cycles per instruction; legal range 2..3 (exec states must fit the 3-bit state encoding).
MULDIV_CYCLES, 32, cycles spent in MULDIV_WAIT; must be >= 1.
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
waitrequest  in  1  memory bus stall; 1 = current access not yet accepted.
mem_access  in  1  from decoder: current exec cycle issues a memory read or write.
exec_len  in  2  from decoder: exec cycles for the current instruction; 0 treated as 1, values above MAX_EXEC clamped to MAX_EXEC.
is_muldiv  in  1  from decoder: instruction is MULT/MULTU/DIV/DIVU.
halt_req  in  1  from datapath: PC target is 0; sampled in the final exec cycle.
state  out  3  current state: HALT=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4, EXEC3=5, MULDIV_WAIT=6.
stall  out  1  combinational: 1 when the state is held by waitrequest this cycle.
active  out  1  0 only in HALT.
muldiv_done  out  1  registered one-cycle pulse on the cycle after MULDIV_WAIT completes.
retire  out  1  combinational one-cycle pulse when an instruction completes.
instr_count  out  COUNT_W  retired-instruction count; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (synchronous, overrides everything, including a reset mid-MULDIV_WAIT or mid-stall): state=FETCH, active=1, muldiv counter=0, latched halt=0, muldiv_done=0, instr_count=0.
- FETCH: waitrequest=1 -> hold, stall=1; otherwise -> DECODE.
- DECODE: always -> EXEC1 after 1 cycle; waitrequest is ignored.
- EXECn with mem_access=1 and waitrequest=1: hold, stall=1. This check takes priority over all other EXECn transitions.
- EXECn with n < effective exec_len: -> EXEC(n+1).
- EXECn with n = effective exec_len (final exec cycle), priority order:
  - is_muldiv=1: -> MULDIV_WAIT; load counter with MULDIV_CYCLES-1; latch halt_req.
  - else halt_req=1: -> HALT; retire=1.
  - else: -> FETCH; retire=1.
- MULDIV_WAIT: counter != 0 -> decrement and hold. Counter = 0 -> go to HALT if the latched halt is set, otherwise FETCH; retire=1; muldiv_done=1 on the following cycle.
- HALT: absorbing state; active=0; only reset exits. waitrequest is ignored.
- instr_count increments by 1 on every retire cycle; all-ones wraps to 0.
- Minimum instruction latency: FETCH + DECODE + exec_len cycles, with no stalls. A mult/div instruction adds MULDIV_CYCLES.
- exec_len, is_muldiv and mem_access are only sampled in EXEC states. Their values in other states have no effect.
- The state encoding is fixed so the control decoder's exec1 = (state==3) and exec2 = (state==4) decode stays valid.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - state_t enum (HALT..MULDIV_WAIT) and its 3-bit encoding;
  - STATE_EXEC_BASE=3;
  - the legal MAX_EXEC bound, checked by an elaboration-time assertion.
- The mult/div wait counter is a natural sub-module, mips_cpu_cycle_counter (load, decrement, zero flag), reusable for future cache-fill waits.
- The state register, next-state logic and retire counter stay in mips_cpu_sequencer.

Test Plan:
- Reset, waitrequest=0, exec_len=1, no muldiv: states 1,2,3,1,2,3; retire once per 3 cycles; instr_count=4 after 12 cycles.
- FETCH with waitrequest=1 for 3 cycles: state held at 1 with stall=1 for those cycles, then DECODE; latency 6 cycles for exec_len=1.
- LW-like instruction, exec_len=2, mem_access=1 in EXEC1, waitrequest=1 for 2 cycles: sequence 3,3,3,4,1; retire only on the EXEC2 exit.
- MULDIV_CYCLES=4, is_muldiv=1, exec_len=1: sequence 3,6,6,6,6,1; muldiv_done high exactly one cycle, the cycle after the last 6.
- halt_req=1 in the final exec of a JR: state 0, active=0, stays 0 for 20 cycles regardless of waitrequest; reset returns state=1, instr_count=0.
- COUNT_W=4, 16 single-exec instructions: instr_count goes 15 -> 0; exec_len=0 behaves as 1 and exec_len=3 with MAX_EXEC=2 behaves as 2.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multicycle MIPS control path: the state encoding
// that the control decoder depends on, and the legal range of exec cycles.
package mips_cpu_pkg;

    // The decoder uses exec1 = (state == 3) and exec2 = (state == 4), so these values are fixed.
    typedef enum logic [2:0] {
        HALT        = 3'd0,
        FETCH       = 3'd1,
        DECODE      = 3'd2,
        EXEC1       = 3'd3,
        EXEC2       = 3'd4,
        EXEC3       = 3'd5,
        MULDIV_WAIT = 3'd6
    } state_t;

    localparam int STATE_EXEC_BASE = 3;
    localparam int MAX_EXEC_LO     = 2;
    localparam int MAX_EXEC_HI     = 3;

    function automatic logic max_exec_legal(input int max_exec);
        return (max_exec >= MAX_EXEC_LO) && (max_exec <= MAX_EXEC_HI);
    endfunction

endpackage

// File: rtl/mips_cpu_cycle_counter.sv
// Loadable down-counter with a zero flag. It holds at zero rather than wrapping,
// so it can time any fixed-length wait (mult/div today, cache fills later).
module mips_cpu_cycle_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multicycle state sequencer: owns the state register consumed by the control
// decoder, handles bus stalls, the mult/div wait phase, halt and retire counting.
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int MAX_EXEC      = 3,
    parameter int MULDIV_CYCLES = 32,
    parameter int COUNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waitrequest,
    input  logic               mem_access,
    input  logic [1:0]         exec_len,
    input  logic               is_muldiv,
    input  logic               halt_req,
    output logic [2:0]         state,
    output logic               stall,
    output logic               active,
    output logic               muldiv_done,
    output logic               retire,
    output logic [COUNT_W-1:0] instr_count
);

    if (!max_exec_legal(MAX_EXEC)) begin : g_bad_max_exec
        $error("mips_cpu_sequencer: MAX_EXEC must be 2..3");
    end
    if (MULDIV_CYCLES < 1) begin : g_bad_muldiv_cycles
        $error("mips_cpu_sequencer: MULDIV_CYCLES must be >= 1");
    end

    localparam int              CNT_W       = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [1:0]      MAX_EXEC_L  = 2'(MAX_EXEC);

    state_t     state_r, state_d;
    logic       halt_latched;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [1:0] eff_len, exec_n;

    mips_cpu_cycle_counter #(.WIDTH(CNT_W)) u_muldiv_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (MULDIV_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        if (exec_len == 2'd0)            eff_len = 2'd1;
        else if (exec_len > MAX_EXEC_L)  eff_len = MAX_EXEC_L;
        else                             eff_len = exec_len;
    end

    // 1-based position within the exec phase; only meaningful in EXEC1..EXEC3.
    assign exec_n = 2'(3'(state_r) - 3'(STATE_EXEC_BASE - 1));

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d  = state_r;
        stall    = 1'b0;
        retire   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_r)
            HALT: ;
            FETCH: begin
                if (waitrequest) stall   = 1'b1;
                else             state_d = DECODE;
            end
            DECODE: state_d = EXEC1;
            EXEC1, EXEC2, EXEC3: begin
                if (mem_access && waitrequest) begin
                    stall = 1'b1;
                end else if (exec_n < eff_len) begin
                    state_d = state_t'(3'(state_r) + 3'd1);
                end else if (is_muldiv) begin
                    state_d  = MULDIV_WAIT;
                    cnt_load = 1'b1;
                end else begin
                    retire  = 1'b1;
                    state_d = halt_req ? HALT : FETCH;
                end
            end
            MULDIV_WAIT: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    retire  = 1'b1;
                    state_d = halt_latched ? HALT : FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FETCH;
            halt_latched <= 1'b0;
            muldiv_done  <= 1'b0;
            instr_count  <= '0;
        end else begin
            state_r     <= state_d;
            muldiv_done <= (state_r == MULDIV_WAIT) && cnt_zero;
            if (cnt_load) halt_latched <= halt_req;
            if (retire)   instr_count  <= instr_count + COUNT_W'(1);
        end
    end

    assign state  = 3'(state_r);
    assign active = (state_r != HALT);

endmodule
